bcd_ex3_seq_ctrl: RTL and testbench

- Sequencing controller for the BCD-to-Excess-3 datapath.
- Accepts a packed multi-digit BCD word over a valid/ready handshake.
- Converts one 4-bit digit per clock through a single shared add-3 converter stage, assembles the Excess-3 result, then presents it on an output valid/ready handshake.
- Sits between a BCD source (keypad/counter front end) and display or arithmetic logic that consumes Excess-3.

---
 rtl/bcd_ex3_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_bcd_ex3_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_ex3_seq_ctrl.sv
// BCD to Excess-3 sequencing controller: one digit per clock via a shared add-3 stage.
// Optional invalid-digit check enabled by defining BCD_INVALID_DIGIT_CHECK_EN.
module bcd_ex3_seq_ctrl #(
    parameter int DIGITS = 4,
    parameter int CW     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_ex3,
    output logic                busy,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [W-1:0]   word_q, word_d;
    logic [W-1:0]   ex3_q, ex3_d;
    logic           valid_q, valid_d;
    logic [3:0]     cur_digit;
    logic           last_digit;
`ifdef BCD_INVALID_DIGIT_CHECK_EN
    logic           err_q, err_d;
`endif

    // Select the digit addressed by the index for the shared converter
    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == CW'(i)) cur_digit = word_q[4*i +: 4];
        end
        last_digit = (idx_q == CW'(DIGITS - 1));
    end

    // Next-state and datapath updates for the IDLE/CONV/DONE sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        ex3_d   = ex3_q;
        valid_d = valid_q;
`ifdef BCD_INVALID_DIGIT_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_bcd;
                    idx_d   = '0;
                    ex3_d   = '0;
`ifdef BCD_INVALID_DIGIT_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == CW'(i)) ex3_d[4*i +: 4] = cur_digit + 4'd3;
                end
`ifdef BCD_INVALID_DIGIT_CHECK_EN
                if (cur_digit > 4'd9) err_d = 1'b1;
`endif
                idx_d = idx_q + CW'(1);
                if (last_digit) begin
                    idx_d   = '0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            ex3_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            ex3_q   <= ex3_d;
            valid_q <= valid_d;
        end
    end

`ifdef BCD_INVALID_DIGIT_CHECK_EN
    // Sticky invalid-digit flag for the word in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign out_ex3   = ex3_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Self-checking bench for bcd_ex3_seq_ctrl: per-cycle model compare plus literal checks.
// Honours BCD_INVALID_DIGIT_CHECK_EN for the expected err behaviour.
module tb_bcd_ex3_seq_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_bcd = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_ex3;
    logic         busy;
    logic         err;

    int total = 0;
    int passed = 0;
    bit chk_en = 1'b0;

`ifdef BCD_INVALID_DIGIT_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    bcd_ex3_seq_ctrl #(.DIGITS(D), .CW(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bcd(in_bcd),
        .out_valid(out_valid), .out_ready(out_ready), .out_ex3(out_ex3),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Behavioural model: word in flight, digits left to convert, result pending
    bit           m_busy, m_valid, m_err;
    int           m_left;
    logic [W-1:0] m_word, m_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_err = 0; m_left = 0; m_out = '0; m_word = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_left = D; m_word = in_bcd; m_out = '0; m_err = 0;
            end
        end else if (m_left > 0) begin
            int k;
            int dg;
            k = D - m_left;
            dg = int'((m_word >> (4 * k)) & 16'hF);
            m_out = m_out | (W'((dg + 3) % 16) << (4 * k));
            if (ERR_ON && dg > 9) m_err = 1;
            m_left--;
            if (m_left == 0) m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0; m_busy = 0;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(!m_busy));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("out_valid", 64'(out_valid), 64'(m_valid));
            chk("out_ex3", 64'(out_ex3), 64'(m_out));
            chk("err", 64'(err), 64'(m_err));
        end
    end

    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bcd = w;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; checks latency, value, err, and completes handshake
    task automatic get(input string name, input logic [W-1:0] exp, input bit exp_err,
                       input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({name, "_latency"}, 64'(n), 64'(D));
        chk({name, "_value"}, 64'(out_ex3), 64'(exp));
        chk({name, "_err"}, 64'(err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({name, "_hold"}, 64'({out_valid, out_ex3}), 64'({1'b1, exp}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_vals", 64'({in_ready, out_valid, busy, err, out_ex3}), 64'({4'b1000, 16'h0000}));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset asserted while idle
        rst_n = 1'b0;
        @(negedge clk);
        chk("idle_rst", 64'({in_ready, out_valid, busy, err, out_ex3}), 64'({4'b1000, 16'h0000}));
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(16'h1234);
        @(negedge clk);
        chk("busy_t1", 64'(busy), 64'(1));
        @(posedge clk); #1;
        // get() starts one cycle late here, so latency would read 3; check it separately
        begin
            int n;
            n = 1;
            @(negedge clk);
            while (!out_valid && n < 50) begin
                @(posedge clk); n++; @(negedge clk);
            end
            chk("w1234_latency", 64'(n), 64'(D));
            chk("w1234_value", 64'(out_ex3), 64'(16'h4567));
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        send(16'h9905);
        get("w9905", 16'hCC38, 1'b0, 5);
        @(negedge clk);
        chk("idle_after", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Second word held on in_valid throughout CONV/DONE
        send(16'h0000);
        in_valid = 1'b1;
        in_bcd = 16'h7777;
        get("w0000", 16'h3333, 1'b0, 2);
        @(negedge clk);
        chk("w7777_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        get("w7777", 16'hAAAA, 1'b0, 0);

        // Reset pulse mid-CONV discards the word
        send(16'h4321);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("conv_rst", 64'({in_ready, out_valid, busy, err, out_ex3}), 64'({4'b1000, 16'h0000}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("no_valid_after_rst", 64'(seen), 64'(0));
        end
        @(posedge clk); #1;
        send(16'h0009);
        get("w0009", 16'h333C, 1'b0, 0);

        send(16'h00A1);
        get("w00A1", 16'h33D4, ERR_ON, 1);
        send(16'h0001);
        get("w0001", 16'h3334, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
